// File: rtl/rhd_spi_pkg.sv
// Shared definitions for the RHD2000-style SPI master: FSM states, word size
// and the command encodings the acquisition sequencer builds commands from.
package rhd_spi_pkg;

    localparam int RHD_WORD_BITS = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEAD  = 3'd1,
        SHIFT = 3'd2,
        TRAIL = 3'd3,
        GAP   = 3'd4
    } rhd_state_e;

    // Two-bit opcode field in cmd[15:14]
    localparam logic [1:0]  RHD_OP_CONVERT     = 2'b00;
    localparam logic [1:0]  RHD_OP_WRITE       = 2'b10;
    localparam logic [1:0]  RHD_OP_READ        = 2'b11;

    // Fixed whole-word commands
    localparam logic [15:0] RHD_CMD_CALIBRATE  = 16'h5500;
    localparam logic [15:0] RHD_CMD_CLEAR      = 16'h6A00;

    function automatic logic [15:0] rhd_cmd_convert(input logic [5:0] channel);
        return {RHD_OP_CONVERT, channel, 8'h00};
    endfunction

    function automatic logic [15:0] rhd_cmd_write(input logic [5:0] reg_addr,
                                                  input logic [7:0] value);
        return {RHD_OP_WRITE, reg_addr, value};
    endfunction

    function automatic logic [15:0] rhd_cmd_read(input logic [5:0] reg_addr);
        return {RHD_OP_READ, reg_addr, 8'h00};
    endfunction

endpackage

// File: rtl/rhd_miso_deser.sv
// One MISO1 lane: shifts in a reply bit on every SCLK rise and presents the
// completed 16-bit word on a held output register when the master loads it.
module rhd_miso_deser
    import rhd_spi_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     sample_en,
    input  logic                     load_en,
    input  logic                     miso,
    output logic [RHD_WORD_BITS-1:0] rx_word
);

    logic [RHD_WORD_BITS-1:0] shift_r;
    logic [RHD_WORD_BITS-1:0] word_r;

    // Serial capture, first sampled bit ends up in the MSB
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_r <= 16'h0000;
        end else if (sample_en) begin
            shift_r <= {shift_r[RHD_WORD_BITS-2:0], miso};
        end else begin
            shift_r <= shift_r;
        end
    end

    // Parallel word held until the next transaction completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_r <= 16'h0000;
        end else if (load_en) begin
            word_r <= shift_r;
        end else begin
            word_r <= word_r;
        end
    end

    assign rx_word = word_r;

endmodule

// File: rtl/rhd_spi_master.sv
// SPI master for RHD2000-style headstages: one 16-bit command out on MOSI per
// transaction, NUM_PORTS reply words captured in parallel from MISO1.
module rhd_spi_master
    import rhd_spi_pkg::*;
#(
    parameter int NUM_PORTS      = 8,
    parameter int CLK_DIV        = 2,
    parameter int CS_HIGH_CYCLES = 8
)
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [15:0]               cmd_data,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    output logic                      CS,
    output logic                      SCLK,
    output logic                      MOSI,
    input  logic [NUM_PORTS-1:0]      MISO1,
    output logic [16*NUM_PORTS-1:0]   rx_data,
    output logic                      rx_valid,
    output logic                      busy
);

    localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_LAST  = 8'(CS_HIGH_CYCLES - 1);
    localparam logic [4:0] BITS_DONE = 5'(RHD_WORD_BITS);

    rhd_state_e  state_r,     state_s;
    logic [7:0]  div_cnt_r,   div_cnt_s;
    logic [4:0]  bit_cnt_r,   bit_cnt_s;
    logic [15:0] cmd_shift_r, cmd_shift_s;
    logic        cs_r,        cs_s;
    logic        sclk_r,      sclk_s;
    logic        mosi_r,      mosi_s;
    logic        rx_valid_r,  rx_valid_s;
    logic        cmd_ready_r;
    logic        busy_r;
    logic        div_done_s;
    logic        sample_en_s;
    logic        load_en_s;

    // Next-state and next-output decode; outputs are registered below
    always_comb begin
        state_s     = state_r;
        div_cnt_s   = div_cnt_r;
        bit_cnt_s   = bit_cnt_r;
        cmd_shift_s = cmd_shift_r;
        cs_s        = cs_r;
        sclk_s      = sclk_r;
        mosi_s      = mosi_r;
        rx_valid_s  = 1'b0;
        sample_en_s = 1'b0;
        load_en_s   = 1'b0;
        div_done_s  = (div_cnt_r == DIV_LAST);

        case (state_r)
            IDLE: begin
                cs_s      = 1'b1;
                sclk_s    = 1'b0;
                mosi_s    = 1'b0;
                div_cnt_s = 8'd0;
                if (cmd_valid && cmd_ready_r) begin
                    // MOSI shifter holds the bits still to be sent; zeros
                    // shift in so MOSI drops to 0 after the last falling edge
                    state_s     = LEAD;
                    cs_s        = 1'b0;
                    mosi_s      = cmd_data[15];
                    cmd_shift_s = {cmd_data[14:0], 1'b0};
                    bit_cnt_s   = 5'd0;
                end else begin
                    state_s = IDLE;
                end
            end

            LEAD: begin
                if (div_done_s) begin
                    state_s     = SHIFT;
                    div_cnt_s   = 8'd0;
                    sclk_s      = 1'b1;
                    sample_en_s = 1'b1;
                end else begin
                    div_cnt_s = div_cnt_r + 8'd1;
                end
            end

            SHIFT: begin
                if (!div_done_s) begin
                    div_cnt_s = div_cnt_r + 8'd1;
                end else if (sclk_r) begin
                    div_cnt_s   = 8'd0;
                    sclk_s      = 1'b0;
                    bit_cnt_s   = bit_cnt_r + 5'd1;
                    mosi_s      = cmd_shift_r[15];
                    cmd_shift_s = {cmd_shift_r[14:0], 1'b0};
                end else if (bit_cnt_r == BITS_DONE) begin
                    // Low half of the 16th period has elapsed
                    div_cnt_s = 8'd0;
                    state_s   = TRAIL;
                end else begin
                    div_cnt_s   = 8'd0;
                    sclk_s      = 1'b1;
                    sample_en_s = 1'b1;
                end
            end

            TRAIL: begin
                if (div_done_s) begin
                    state_s    = GAP;
                    div_cnt_s  = 8'd0;
                    cs_s       = 1'b1;
                    rx_valid_s = 1'b1;
                    load_en_s  = 1'b1;
                end else begin
                    div_cnt_s = div_cnt_r + 8'd1;
                end
            end

            GAP: begin
                if (div_cnt_r == GAP_LAST) begin
                    state_s   = IDLE;
                    div_cnt_s = 8'd0;
                end else begin
                    div_cnt_s = div_cnt_r + 8'd1;
                end
            end

            default: begin
                state_s   = IDLE;
                div_cnt_s = 8'd0;
                bit_cnt_s = 5'd0;
                cs_s      = 1'b1;
                sclk_s    = 1'b0;
                mosi_s    = 1'b0;
            end
        endcase
    end

    // State, counters and registered bus outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            div_cnt_r   <= 8'd0;
            bit_cnt_r   <= 5'd0;
            cmd_shift_r <= 16'h0000;
            cs_r        <= 1'b1;
            sclk_r      <= 1'b0;
            mosi_r      <= 1'b0;
            rx_valid_r  <= 1'b0;
            cmd_ready_r <= 1'b1;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            div_cnt_r   <= div_cnt_s;
            bit_cnt_r   <= bit_cnt_s;
            cmd_shift_r <= cmd_shift_s;
            cs_r        <= cs_s;
            sclk_r      <= sclk_s;
            mosi_r      <= mosi_s;
            rx_valid_r  <= rx_valid_s;
            cmd_ready_r <= (state_s == IDLE);
            busy_r      <= (state_s != IDLE);
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        rhd_miso_deser u_deser (
            .clk       (clk),
            .rst_n     (rst_n),
            .sample_en (sample_en_s),
            .load_en   (load_en_s),
            .miso      (MISO1[p]),
            .rx_word   (rx_data[16*p +: 16])
        );
    end

    assign cmd_ready = cmd_ready_r;
    assign CS        = cs_r;
    assign SCLK      = sclk_r;
    assign MOSI      = mosi_r;
    assign rx_valid  = rx_valid_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_rhd_spi_master.sv
// Directed bench for rhd_spi_master: default timing instance plus a
// CLK_DIV=1 / CS_HIGH_CYCLES=1 instance for back-to-back throughput.
module tb_rhd_spi_master;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;

    logic [15:0]  cmd_data = 16'h0000;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready, cs, sclk, mosi, rx_valid, busy;
    logic [7:0]   miso;
    logic [127:0] rx_data;

    logic [15:0]  cmd_data_f = 16'h0000;
    logic         cmd_valid_f = 1'b0;
    logic         cmd_ready_f, cs_f, sclk_f, mosi_f, rx_valid_f, busy_f;
    logic [7:0]   miso_f;
    logic [127:0] rx_data_f;

    logic [1:0]   miso_mode = 2'd0;
    logic [7:0]   stub_bits;
    logic [3:0]   stub_idx;
    logic         stub_clr = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    // Observations recorded by run_txn
    int           cs_low_cnt, cs_first, cs_last, rise_cnt, first_rise;
    int           rv_cnt, rv_cycle, ready_cycle, sclk_cs_hi;
    logic [15:0]  mosi_cap;
    logic [127:0] rx_snap, rx_end;

    always #5 clk = ~clk;

    rhd_spi_master dut (
        .clk(clk), .rst_n(rst_n), .cmd_data(cmd_data), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .CS(cs), .SCLK(sclk), .MOSI(mosi), .MISO1(miso),
        .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy)
    );

    rhd_spi_master #(.NUM_PORTS(8), .CLK_DIV(1), .CS_HIGH_CYCLES(1)) dut_fast (
        .clk(clk), .rst_n(rst_n), .cmd_data(cmd_data_f), .cmd_valid(cmd_valid_f),
        .cmd_ready(cmd_ready_f), .CS(cs_f), .SCLK(sclk_f), .MOSI(mosi_f), .MISO1(miso_f),
        .rx_data(rx_data_f), .rx_valid(rx_valid_f), .busy(busy_f)
    );

    assign miso_f = {8{mosi_f}};
    assign miso   = (miso_mode == 2'd1) ? {8{mosi}} :
                    (miso_mode == 2'd2) ? stub_bits : 8'h00;

    // Stub slave: port p replies with the word p, next bit after each SCLK fall
    always @(negedge sclk or posedge stub_clr) begin
        if (stub_clr) stub_idx <= 4'd15;
        else          stub_idx <= stub_idx - 4'd1;
    end

    always_comb begin
        logic [15:0] w;
        for (int p = 0; p < 8; p++) begin
            w = 16'(p);
            stub_bits[p] = w[stub_idx];
        end
    end

    // Issue one command on the default instance and record bus activity for ncyc cycles
    task automatic run_txn(input logic [15:0] cmd, input int ncyc);
        logic prev_sclk;
        cs_low_cnt = 0; cs_first = -1; cs_last = -1; rise_cnt = 0; first_rise = -1;
        rv_cnt = 0; rv_cycle = -1; ready_cycle = -1; sclk_cs_hi = 0;
        mosi_cap = 16'h0000; rx_snap = 128'd0; prev_sclk = 1'b0;
        @(posedge clk); #1;
        cmd_data = cmd; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_data = ~cmd;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            if (!cs) begin
                cs_low_cnt++;
                if (cs_first < 0) cs_first = c;
                cs_last = c;
            end
            if (sclk && cs) sclk_cs_hi++;
            if (sclk && !prev_sclk) begin
                if (first_rise < 0) first_rise = c;
                if (rise_cnt < 16) mosi_cap[15 - rise_cnt] = mosi;
                rise_cnt++;
            end
            prev_sclk = sclk;
            if (rx_valid) begin
                rv_cnt++;
                rv_cycle = c;
                rx_snap = rx_data;
            end
            if (cmd_ready && ready_cycle < 0) ready_cycle = c;
        end
        rx_end = rx_data;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        n_cmp++;
        if ({cs, sclk, mosi, busy, rx_valid} !== 5'b10000) begin
            n_bad++;
            $display("FAIL reset_in_reset: cs/sclk/mosi/busy/rx_valid got %b want 10000",
                     {cs, sclk, mosi, busy, rx_valid});
        end
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({cs, sclk, mosi, cmd_ready, busy, rx_valid} !== 6'b100100) begin
                n_bad++;
                $display("FAIL reset_idle c%0d: cs/sclk/mosi/ready/busy/rv got %b want 100100",
                         c, {cs, sclk, mosi, cmd_ready, busy, rx_valid});
            end
        end
        n_cmp++;
        if (rx_data !== 128'd0) begin
            n_bad++;
            $display("FAIL reset_rx_data: got %h want 0", rx_data);
        end
    endtask

    task automatic test_single();
        miso_mode = 2'd0;
        run_txn(16'hA5C3, 90);
        n_cmp++; if (cs_low_cnt !== 68) begin n_bad++; $display("FAIL single_cs_low_cycles: got %0d want 68", cs_low_cnt); end
        n_cmp++; if (cs_first !== 1) begin n_bad++; $display("FAIL single_cs_first: got %0d want 1", cs_first); end
        n_cmp++; if (cs_last !== 68) begin n_bad++; $display("FAIL single_cs_last: got %0d want 68", cs_last); end
        n_cmp++; if (rise_cnt !== 16) begin n_bad++; $display("FAIL single_sclk_pulses: got %0d want 16", rise_cnt); end
        n_cmp++; if (first_rise !== 3) begin n_bad++; $display("FAIL single_first_rise: got %0d want 3", first_rise); end
        n_cmp++; if (mosi_cap !== 16'hA5C3) begin n_bad++; $display("FAIL single_mosi_bits: got %h want a5c3", mosi_cap); end
        n_cmp++; if (rv_cnt !== 1 || rv_cycle !== 69) begin n_bad++; $display("FAIL single_rx_valid: got %0d pulses at %0d want 1 at 69", rv_cnt, rv_cycle); end
        n_cmp++; if (ready_cycle !== 77) begin n_bad++; $display("FAIL single_ready_return: got %0d want 77", ready_cycle); end
        n_cmp++; if (sclk_cs_hi !== 0) begin n_bad++; $display("FAIL single_sclk_with_cs_high: got %0d want 0", sclk_cs_hi); end
        n_cmp++; if (rx_snap !== 128'd0) begin n_bad++; $display("FAIL single_rx_zero: got %h want 0", rx_snap); end
    endtask

    task automatic test_loopback();
        miso_mode = 2'd1;
        run_txn(16'h1234, 90);
        n_cmp++; if (rv_cycle !== 69) begin n_bad++; $display("FAIL loop_rx_valid_cycle: got %0d want 69", rv_cycle); end
        for (int p = 0; p < 8; p++) begin
            n_cmp++;
            if (rx_snap[16*p +: 16] !== 16'h1234) begin
                n_bad++;
                $display("FAIL loop_port%0d: got %h want 1234", p, rx_snap[16*p +: 16]);
            end
        end
        n_cmp++; if (rx_end !== {8{16'h1234}}) begin n_bad++; $display("FAIL loop_rx_held: got %h want all 1234", rx_end); end
    endtask

    task automatic test_per_port();
        miso_mode = 2'd2;
        stub_clr = 1'b1; #1; stub_clr = 1'b0;
        run_txn(16'h0F0F, 90);
        n_cmp++; if (rv_cnt !== 1) begin n_bad++; $display("FAIL port_rx_valid_count: got %0d want 1", rv_cnt); end
        for (int p = 0; p < 8; p++) begin
            n_cmp++;
            if (rx_snap[16*p +: 16] !== 16'(p)) begin
                n_bad++;
                $display("FAIL port_capture%0d: got %h want %h", p, rx_snap[16*p +: 16], 16'(p));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] cmds [3];
        logic [127:0] got [3];
        int t [3];
        int acc0, sent, pulses, cs_runs;
        logic acc, prev_cs;
        cmds[0] = 16'hFFFF; cmds[1] = 16'h0001; cmds[2] = 16'h8421;
        acc0 = -1; sent = 0; pulses = 0; cs_runs = 0; prev_cs = 1'b1;
        for (int k = 0; k < 3; k++) begin t[k] = -1; got[k] = 128'd0; end
        @(posedge clk); #1;
        cmd_data_f = cmds[0]; cmd_valid_f = 1'b1;
        for (int n = 0; n < 130; n++) begin
            @(negedge clk);
            if (rx_valid_f) begin
                if (pulses < 3) begin t[pulses] = n; got[pulses] = rx_data_f; end
                pulses++;
            end
            if (!cs_f && prev_cs) cs_runs++;
            prev_cs = cs_f;
            acc = cmd_valid_f && cmd_ready_f;
            @(posedge clk); #1;
            if (acc) begin
                if (acc0 < 0) acc0 = n;
                sent++;
                if (sent < 3) cmd_data_f = cmds[sent];
                else cmd_valid_f = 1'b0;
            end
        end
        n_cmp++; if (pulses !== 3) begin n_bad++; $display("FAIL b2b_pulses: got %0d want 3", pulses); end
        n_cmp++; if (t[0] - acc0 !== 35) begin n_bad++; $display("FAIL b2b_first_latency: got %0d want 35", t[0] - acc0); end
        n_cmp++; if (t[1] - t[0] !== 36) begin n_bad++; $display("FAIL b2b_spacing01: got %0d want 36", t[1] - t[0]); end
        n_cmp++; if (t[2] - t[1] !== 36) begin n_bad++; $display("FAIL b2b_spacing12: got %0d want 36", t[2] - t[1]); end
        n_cmp++; if (cs_runs !== 3) begin n_bad++; $display("FAIL b2b_cs_runs: got %0d want 3", cs_runs); end
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (got[k] !== {8{cmds[k]}}) begin
                n_bad++;
                $display("FAIL b2b_data%0d: got %h want all %h", k, got[k], cmds[k]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int rises, late_rv;
        logic prev;
        miso_mode = 2'd1;
        rises = 0; prev = 1'b0; late_rv = 0;
        @(posedge clk); #1;
        cmd_data = 16'h5500; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int c = 0; c < 100 && rises < 7; c++) begin
            @(negedge clk);
            if (sclk && !prev) rises++;
            prev = sclk;
        end
        n_cmp++; if (rises !== 7) begin n_bad++; $display("FAIL mid_reach_7_pulses: got %0d want 7", rises); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({cs, sclk, mosi, busy, rx_valid} !== 5'b10000) begin
            n_bad++;
            $display("FAIL mid_async_outputs: cs/sclk/mosi/busy/rv got %b want 10000",
                     {cs, sclk, mosi, busy, rx_valid});
        end
        n_cmp++; if (rx_data !== 128'd0) begin n_bad++; $display("FAIL mid_rx_cleared: got %h want 0", rx_data); end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (rx_valid) late_rv++;
        end
        n_cmp++; if (late_rv !== 0) begin n_bad++; $display("FAIL mid_no_rx_valid: got %0d want 0", late_rv); end
        run_txn(16'hC3A5, 90);
        n_cmp++; if (cs_low_cnt !== 68) begin n_bad++; $display("FAIL mid_next_cs_low: got %0d want 68", cs_low_cnt); end
        n_cmp++; if (rv_cnt !== 1 || rv_cycle !== 69) begin n_bad++; $display("FAIL mid_next_rx_valid: got %0d at %0d want 1 at 69", rv_cnt, rv_cycle); end
        n_cmp++; if (rx_snap !== {8{16'hC3A5}}) begin n_bad++; $display("FAIL mid_next_data: got %h want all c3a5", rx_snap); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_loopback();
        test_per_port();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
